// File: rtl/mux16_sel_sequencer.sv
// mux16_sel_sequencer
//   Upstream sequencer for a 16-to-1 mux stage. A 16-bit word is accepted over
//   a valid/ready handshake and held on the mux data bus. The mux select then
//   steps through all 16 positions. Each position is held for DWELL cycles
//   before the mux output is sampled. The sampled bits leave as a serial
//   stream with valid/last strobes.
//
// Parameters
//   DWELL      cycles each select value is held before sampling (1..15)
//   MSB_FIRST  0: mux_sel steps 0 -> 15, 1: mux_sel steps 15 -> 0
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ld_data    word to serialize
//   ld_valid   ld_data valid
//   ld_ready   block can accept a word (IDLE)
//   abort      synchronous cancel of the current scan
//   mux_in     registered word driven to the mux data input
//   mux_sel    registered select driven to the mux
//   mux_out    mux output, combinational from mux_in/mux_sel
//   ser_data   sampled serial bit (holds when ser_valid is low)
//   ser_valid  one-cycle strobe, ser_data valid
//   ser_last   high with ser_valid on the 16th bit of a word
//   busy       high while scanning
module mux16_sel_sequencer #(
  parameter int DWELL     = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ld_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic        abort,
  output logic [15:0] mux_in,
  output logic [3:0]  mux_sel,
  input  logic        mux_out,
  output logic        ser_data,
  output logic        ser_valid,
  output logic        ser_last,
  output logic        busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [3:0] START_SEL  = MSB_FIRST ? 4'd15 : 4'd0;
  localparam logic [3:0] END_SEL    = MSB_FIRST ? 4'd0  : 4'd15;
  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  dwell_cnt_r;
  logic [3:0]  dwell_cnt_s;
  logic [15:0] mux_in_s;
  logic [3:0]  mux_sel_s;
  logic        ser_data_s;
  logic        ser_valid_s;
  logic        ser_last_s;

  // Handshake and status are decoded straight from the registered state.
  assign ld_ready = (state_r == IDLE);
  assign busy     = (state_r == SCAN);

  // Next-state and next-output logic for the IDLE/SCAN scan controller.
  always_comb begin
    state_s     = state_r;
    dwell_cnt_s = dwell_cnt_r;
    mux_in_s    = mux_in;
    mux_sel_s   = mux_sel;
    ser_data_s  = ser_data;
    ser_valid_s = 1'b0;
    ser_last_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (ld_valid) begin
          mux_in_s    = ld_data;
          mux_sel_s   = START_SEL;
          dwell_cnt_s = 4'd0;
          state_s     = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        // abort takes priority over a coinciding sample edge
        if (abort) begin
          state_s     = IDLE;
          mux_sel_s   = START_SEL;
          dwell_cnt_s = 4'd0;
        end else if (dwell_cnt_r == DWELL_LAST) begin
          ser_data_s  = mux_out;
          ser_valid_s = 1'b1;
          dwell_cnt_s = 4'd0;
          // the end index terminates the scan, so the select never wraps
          if (mux_sel == END_SEL) begin
            ser_last_s = 1'b1;
            state_s    = IDLE;
            mux_sel_s  = START_SEL;
          end else if (MSB_FIRST) begin
            mux_sel_s = mux_sel - 4'd1;
          end else begin
            mux_sel_s = mux_sel + 4'd1;
          end
        end else begin
          dwell_cnt_s = dwell_cnt_r + 4'd1;
        end
      end
      default: begin
        state_s     = IDLE;
        mux_sel_s   = START_SEL;
        dwell_cnt_s = 4'd0;
      end
    endcase
  end

  // State, mux drive and serial output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      dwell_cnt_r <= 4'd0;
      mux_in      <= 16'd0;
      mux_sel     <= START_SEL;
      ser_data    <= 1'b0;
      ser_valid   <= 1'b0;
      ser_last    <= 1'b0;
    end else begin
      state_r     <= state_s;
      dwell_cnt_r <= dwell_cnt_s;
      mux_in      <= mux_in_s;
      mux_sel     <= mux_sel_s;
      ser_data    <= ser_data_s;
      ser_valid   <= ser_valid_s;
      ser_last    <= ser_last_s;
    end
  end

endmodule

// File: tb/tb_mux16_sel_sequencer.sv
// Self-checking bench for mux16_sel_sequencer.
// Three instances cover the configurations of interest:
//   idx 0: DWELL=1, MSB_FIRST=0
//   idx 1: DWELL=1, MSB_FIRST=1
//   idx 2: DWELL=3, MSB_FIRST=0
// The reference is a timeline model: after accept edge E0, bit k of the word
// (in scan order) appears after edge E((k+1)*DWELL), the select sits at the
// scan position floor(t/DWELL), and the block is idle again after E(16*DWELL).
module tb_mux16_sel_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] ld_data   [3];
  logic        ld_valid  [3];
  logic        ld_ready  [3];
  logic        abort     [3];
  logic [15:0] mux_in    [3];
  logic [3:0]  mux_sel   [3];
  logic        mux_out   [3];
  logic        ser_data  [3];
  logic        ser_valid [3];
  logic        ser_last  [3];
  logic        busy      [3];

  // Model of the most recently emitted bit per instance (ser_data holds it).
  logic        exp_bit   [3];

  int total;
  int bad;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    // Behavioural 16-to-1 mux closing the loop around each sequencer.
    assign mux_out[g] = mux_in[g][mux_sel[g]];

    mux16_sel_sequencer #(
      .DWELL     ((g == 2) ? 3 : 1),
      .MSB_FIRST ((g == 1) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_data   (ld_data[g]),
      .ld_valid  (ld_valid[g]),
      .ld_ready  (ld_ready[g]),
      .abort     (abort[g]),
      .mux_in    (mux_in[g]),
      .mux_sel   (mux_sel[g]),
      .mux_out   (mux_out[g]),
      .ser_data  (ser_data[g]),
      .ser_valid (ser_valid[g]),
      .ser_last  (ser_last[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one word through instance idx and check every cycle of its scan.
  //   abort_k  >= 0: abort on the edge where bit abort_k would be sampled
  //   stop_t   >  0: leave after the check following edge E(stop_t)
  //   chain       : keep ld_valid high with next_word and check its accept
  //   pre         : word was already accepted (we are just after E0)
  task automatic scan_word(input int idx, input logic [15:0] word, input int abort_k,
                           input int stop_t, input bit chain, input logic [15:0] next_word,
                           input bit pre);
    int dw;
    bit msb;
    int last_t;
    int pulses;
    int lasts;
    logic [3:0] start;
    dw     = (idx == 2) ? 3 : 1;
    msb    = (idx == 1);
    start  = msb ? 4'd15 : 4'd0;
    pulses = 0;
    lasts  = 0;
    if (!pre) begin
      ld_data[idx]  = word;
      ld_valid[idx] = 1'b1;
      @(posedge clk); #1;
    end
    ld_valid[idx] = chain;
    ld_data[idx]  = chain ? next_word : 16'($urandom);
    last_t = (abort_k >= 0) ? (abort_k + 1) * dw : 16 * dw;
    for (int t = 1; t <= last_t; t++) begin
      bit done;
      bit samp;
      int k;
      logic [3:0]  esel;
      logic [24:0] exp_v;
      logic [24:0] got_v;
      if (abort_k >= 0 && t == last_t) abort[idx] = 1'b1;
      @(posedge clk); #1;
      abort[idx] = 1'b0;
      done = (t == last_t);
      samp = (t % dw == 0) && !(abort_k >= 0 && done);
      k    = t / dw - 1;
      if (samp) exp_bit[idx] = word[msb ? 15 - k : k];
      esel  = done ? start : (msb ? 4'(15 - t / dw) : 4'(t / dw));
      exp_v = {!done, done, samp, samp && (k == 15), exp_bit[idx], esel, word};
      got_v = {busy[idx], ld_ready[idx], ser_valid[idx], ser_last[idx], ser_data[idx],
               mux_sel[idx], mux_in[idx]};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL scan idx=%0d word=%h t=%0d got{busy,rdy,v,l,d,sel,in}=%h exp=%h",
                 idx, word, t, got_v, exp_v);
      end
      pulses += int'(ser_valid[idx]);
      lasts  += int'(ser_last[idx]);
      if (t == stop_t) break;
    end
    if (stop_t == 0) begin
      total++;
      if (pulses != ((abort_k >= 0) ? abort_k : 16) || lasts != ((abort_k >= 0) ? 0 : 1)) begin
        bad++;
        $display("FAIL pulse_count idx=%0d word=%h got valid=%0d last=%0d exp valid=%0d last=%0d",
                 idx, word, pulses, lasts, (abort_k >= 0) ? abort_k : 16,
                 (abort_k >= 0) ? 0 : 1);
      end
    end
    if (chain) begin
      // next word is taken at E(16*DWELL+1)
      @(posedge clk); #1;
      total++;
      if (busy[idx] !== 1'b1 || mux_in[idx] !== next_word || mux_sel[idx] !== start ||
          ser_valid[idx] !== 1'b0) begin
        bad++;
        $display("FAIL chain_accept idx=%0d got busy=%b in=%h sel=%0d v=%b exp busy=1 in=%h sel=%0d v=0",
                 idx, busy[idx], mux_in[idx], mux_sel[idx], ser_valid[idx], next_word, start);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      ld_data[i] = 16'($urandom);
      ld_valid[i] = 1'b1;
      abort[i] = 1'b1;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mux_in[i] !== 16'd0 || mux_sel[i] !== ((i == 1) ? 4'd15 : 4'd0) ||
          ser_data[i] !== 1'b0 || ser_valid[i] !== 1'b0 || ser_last[i] !== 1'b0 ||
          busy[i] !== 1'b0 || ld_ready[i] !== 1'b1) begin
        bad++;
        $display("FAIL reset idx=%0d got in=%h sel=%0d d=%b v=%b l=%b busy=%b rdy=%b",
                 idx_str(i), mux_in[i], mux_sel[i], ser_data[i], ser_valid[i], ser_last[i],
                 busy[i], ld_ready[i]);
      end
      ld_valid[i] = 1'b0;
      abort[i] = 1'b0;
      exp_bit[i] = 1'b0;
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic int idx_str(input int i);
    return i;
  endfunction

  task automatic test_lsb_first();
    scan_word(0, 16'hAAAA, -1, 0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_msb_first();
    scan_word(1, 16'h8001, -1, 0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_dwell3();
    scan_word(2, 16'h00F0, -1, 0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    scan_word(0, 16'h1234, -1, 0, 1'b1, 16'hFFFF, 1'b0);
    scan_word(0, 16'hFFFF, -1, 0, 1'b0, 16'h0000, 1'b1);
    scan_word(2, 16'hC3A5, -1, 0, 1'b1, 16'h5A3C, 1'b0);
    scan_word(2, 16'h5A3C, -1, 0, 1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_abort();
    logic [15:0] w;
    scan_word(0, 16'hFFFF, 5, 0, 1'b0, 16'h0000, 1'b0);
    // abort is ignored in IDLE: a word offered together with abort is taken
    w = 16'($urandom);
    ld_data[0]  = w;
    ld_valid[0] = 1'b1;
    abort[0]    = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    total++;
    if (busy[0] !== 1'b1 || mux_in[0] !== w) begin
      bad++;
      $display("FAIL abort_idle idx=0 got busy=%b in=%h exp busy=1 in=%h", busy[0], mux_in[0], w);
    end
    scan_word(0, w, -1, 0, 1'b0, 16'h0000, 1'b1);
    scan_word(2, 16'hFFFF, 9, 0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_reset_midscan();
    scan_word(0, 16'hFFFF, -1, 9, 1'b0, 16'h0000, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mux_in[i] !== 16'd0 || mux_sel[i] !== ((i == 1) ? 4'd15 : 4'd0) ||
          ser_data[i] !== 1'b0 || ser_valid[i] !== 1'b0 || ser_last[i] !== 1'b0 ||
          busy[i] !== 1'b0 || ld_ready[i] !== 1'b1) begin
        bad++;
        $display("FAIL async_reset idx=%0d got in=%h sel=%0d d=%b v=%b l=%b busy=%b rdy=%b",
                 i, mux_in[i], mux_sel[i], ser_data[i], ser_valid[i], ser_last[i],
                 busy[i], ld_ready[i]);
      end
      exp_bit[i] = 1'b0;
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    scan_word(0, 16'h5555, -1, 0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 3; i++) begin
        int gap;
        gap = int'($urandom_range(0, 3));
        for (int c = 0; c < gap; c++) begin
          ld_data[i] = 16'($urandom);
          @(posedge clk); #1;
        end
        scan_word(i, 16'($urandom), -1, 0, 1'b0, 16'h0000, 1'b0);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_data[i]  = 16'd0;
      ld_valid[i] = 1'b0;
      abort[i]    = 1'b0;
      exp_bit[i]  = 1'b0;
    end
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_dwell3();
    test_back_to_back();
    test_abort();
    test_reset_midscan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
